register_pipe: RTL

REGISTER_PIPE -- requirements
Module: register_pipe

---
 rtl/register_pkg.sv | 21 ++
 rtl/register_pipe_if.sv | 31 +++
 rtl/skid_stage.sv | 83 ++++++++
 rtl/register_pipe.sv | 88 ++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared types and sizing helpers for the register pipe and its skid stages.
package register_pkg;

  // Occupancy of one two-entry skid stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Total words the pipe can hold.
  function automatic int unsigned capacity(input int unsigned stages);
    return 2 * stages;
  endfunction

  // Bits needed for an occupancy counter spanning 0..capacity.
  function automatic int unsigned cnt_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/register_pipe_if.sv
// Valid/ready handshake bundle plus occupancy status for the register pipe.
interface register_pipe_if
  import register_pkg::*;
#(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned STAGES = 2
);

  localparam int unsigned CNT_W = cnt_width(STAGES);

  logic             in_valid;
  logic [WIDTH-1:0] din;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] dout;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  // Producer/consumer side that drives words in and takes them out.
  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, count
  );

  // The pipe itself.
  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, count
  );

endinterface

// File: rtl/skid_stage.sv
// Two-entry skid buffer: registered up_ready and dn_valid, data out of main.
module skid_stage
  import register_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);

  stage_state_e     state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             ready_q;
  logic             valid_q;
  logic             push;
  logic             pop;

  // Handshake decode against the registered flags only.
  assign push = up_valid_i & ready_q;
  assign pop  = valid_q & dn_ready_i;

  // Occupancy FSM; flags track state so ready == !FULL and valid == !EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_q  <= up_data_i;
            state_q <= HALF;
            valid_q <= 1'b1;
          end
        end
        HALF: begin
          if (push && !pop) begin
            skid_q  <= up_data_i;
            state_q <= FULL;
            ready_q <= 1'b0;
          end else if (push && pop) begin
            main_q <= up_data_i;
          end else if (pop) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= HALF;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign up_ready_o = ready_q;
  assign dn_valid_o = valid_q;
  assign dn_data_o  = main_q;

endmodule

// File: rtl/register_pipe.sv
// Cascade of skid stages with global enable, synchronous flush and occupancy count.
module register_pipe
  import register_pkg::*;
#(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  register_pipe_if.slave    bus
);

  localparam int unsigned CNT_W = cnt_width(STAGES);

  logic             stage_valid [STAGES];
  logic             stage_ready [STAGES];
  logic [WIDTH-1:0] stage_data  [STAGES];
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Chain of stages; en gates every link so nothing moves while it is low.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_ready;

    if (k == 0) begin : g_first
      assign up_valid = bus.in_valid & en;
      assign up_data  = bus.din;
    end else begin : g_next
      assign up_valid = stage_valid[k-1] & en;
      assign up_data  = stage_data[k-1];
    end

    if (k == int'(STAGES) - 1) begin : g_last
      assign dn_ready = bus.out_ready & en;
    end else begin : g_inner
      assign dn_ready = stage_ready[k+1] & en;
    end

    skid_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (reset),
      .flush_i    (flush),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .up_ready_o (stage_ready[k]),
      .dn_valid_o (stage_valid[k]),
      .dn_data_o  (stage_data[k]),
      .dn_ready_i (dn_ready)
    );
  end

  assign bus.in_ready  = stage_ready[0] & en;
  assign bus.out_valid = stage_valid[STAGES-1] & en;
  assign bus.dout      = stage_data[STAGES-1];

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  // Occupancy next value: flush clears, simultaneous in/out cancel.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.count = count_q;

endmodule
